// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline memory stage.
package mips_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Size 2'b11 is handled as a word access everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic r;
        case (size)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = lo[0];
            default: r = (lo != 2'b00);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 32-bit little-endian data bus: store replication
// with byte enables, and load extraction with sign/zero extension.
module mem_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_unsigned,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_lane, 3'b000} +: 8];
    assign w_half = i_rdata[{i_lane[1], 4'b0000} +: 16];

    // Replicate store data across lanes and enable only the addressed bytes.
    always_comb begin
        o_wdata = i_store_data;
        o_be    = 4'b1111;
        case (i_size)
            SZ_BYTE: begin
                o_wdata = {4{i_store_data[7:0]}};
                o_be    = 4'b0001 << i_lane;
            end
            SZ_HALF: begin
                o_wdata = {2{i_store_data[15:0]}};
                o_be    = 4'b0011 << i_lane;
            end
            default: ;
        endcase
    end

    // Pick the addressed byte/half out of the read word and extend it.
    always_comb begin
        o_load_data = i_rdata;
        case (i_size)
            SZ_BYTE: o_load_data = i_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: o_load_data = i_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues handshaked loads/stores, stalls upstream while an access
// is outstanding and registers results into the MEM/WB boundary.
//
//   state     | meaning
//   ST_IDLE   | accepting from EX/MEM; ALU ops pass through in one cycle
//   ST_ACCESS | request on the bus, waiting for mem_ready
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       in_alu_result,
    input  logic [31:0]       in_store_data,
    input  logic              in_MemRead,
    input  logic              in_MemWrite,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic              in_MemtoReg,
    input  logic              in_DataC,
    input  logic              in_RegWrite,
    input  logic [REG_W-1:0]  in_write_reg,
    input  logic [31:0]       in_pc_adder,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [31:0]       alu_result,
    output logic [31:0]       read_data_mem,
    output logic              MemtoReg,
    output logic              DataC,
    output logic [31:0]       pc_adder,
    output logic              RegWrite,
    output logic [REG_W-1:0]  write_reg,
    output logic              misaligned
);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [31:0]        r_h_alu;
    logic [31:0]        r_h_pc;
    logic               r_h_memtoreg;
    logic               r_h_datac;
    logic               r_h_regwrite;
    logic [REG_W-1:0]   r_h_wreg;
    logic [1:0]         r_h_size;
    logic [1:0]         r_h_lane;
    logic               r_h_unsigned;

    logic               w_mem_op;
    logic               w_misalign;
    logic               w_idle;
    logic               w_accept;
    logic               w_squash;
    logic               w_pass;
    logic               w_done;
    logic [1:0]         w_al_size;
    logic [1:0]         w_al_lane;
    logic               w_al_unsigned;
    logic [31:0]        w_wdata;
    logic [3:0]         w_be;
    logic [31:0]        w_load_data;

    assign w_mem_op   = in_MemRead | in_MemWrite;
    assign w_misalign = is_misaligned(in_size, in_alu_result[1:0]);
    assign w_idle     = (r_state == ST_IDLE);
    assign w_accept   = w_idle && in_valid && w_mem_op && !w_misalign;
    assign w_squash   = w_idle && in_valid && w_mem_op && w_misalign;
    assign w_pass     = w_idle && in_valid && !w_mem_op;
    assign w_done     = (r_state == ST_ACCESS) && mem_ready;

    // One aligner serves both directions: stores are formatted from the
    // incoming op at acceptance, loads are extracted using the held op.
    assign w_al_size     = w_idle ? in_size            : r_h_size;
    assign w_al_lane     = w_idle ? in_alu_result[1:0] : r_h_lane;
    assign w_al_unsigned = w_idle ? in_unsigned        : r_h_unsigned;

    mem_lane_align u_align (
        .i_size       (w_al_size),
        .i_lane       (w_al_lane),
        .i_unsigned   (w_al_unsigned),
        .i_store_data (in_store_data),
        .i_rdata      (mem_rdata),
        .o_wdata      (w_wdata),
        .o_be         (w_be),
        .o_load_data  (w_load_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and combinational stall.
    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                stall = w_accept;
                if (w_accept) w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                stall = !mem_ready;
                if (mem_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus outputs: loaded at acceptance, held through the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else if (w_accept) begin
            mem_req   <= 1'b1;
            mem_we    <= in_MemWrite;
            mem_addr  <= {in_alu_result[ADDR_W-1:2], 2'b00};
            mem_wdata <= w_wdata;
            mem_be    <= w_be;
        end else if (w_done) begin
            mem_req   <= 1'b0;
        end
    end

    // Holding registers for the instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_alu      <= '0;
            r_h_pc       <= '0;
            r_h_memtoreg <= 1'b0;
            r_h_datac    <= 1'b0;
            r_h_regwrite <= 1'b0;
            r_h_wreg     <= '0;
            r_h_size     <= '0;
            r_h_lane     <= '0;
            r_h_unsigned <= 1'b0;
        end else if (w_accept) begin
            r_h_alu      <= in_alu_result;
            r_h_pc       <= in_pc_adder;
            r_h_memtoreg <= in_MemtoReg;
            r_h_datac    <= in_DataC;
            r_h_regwrite <= in_RegWrite;
            r_h_wreg     <= in_write_reg;
            r_h_size     <= in_size;
            r_h_lane     <= in_alu_result[1:0];
            r_h_unsigned <= in_unsigned;
        end
    end

    // MEM/WB boundary registers; anything that is not a completion is a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid      <= 1'b0;
            alu_result    <= '0;
            read_data_mem <= '0;
            MemtoReg      <= 1'b0;
            DataC         <= 1'b0;
            pc_adder      <= '0;
            RegWrite      <= 1'b0;
            write_reg     <= '0;
            misaligned    <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            misaligned <= w_squash;
            if (w_pass) begin
                wb_valid      <= 1'b1;
                alu_result    <= in_alu_result;
                read_data_mem <= '0;
                MemtoReg      <= in_MemtoReg;
                DataC         <= in_DataC;
                pc_adder      <= in_pc_adder;
                RegWrite      <= in_RegWrite;
                write_reg     <= in_write_reg;
            end else if (w_done) begin
                wb_valid      <= 1'b1;
                alu_result    <= r_h_alu;
                read_data_mem <= mem_we ? 32'b0 : w_load_data;
                MemtoReg      <= r_h_memtoreg;
                DataC         <= r_h_datac;
                pc_adder      <= r_h_pc;
                RegWrite      <= r_h_regwrite;
                write_reg     <= r_h_wreg;
            end else begin
                RegWrite      <= 1'b0;
            end
        end
    end

endmodule
